// File: rtl/register_file.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | register_file : DEPTH x WIDTH register file with per-register valid bits,   |
// | registered bus read port and synchronous clear. Optional macro              |
// | REGFILE_BYPASS_EN forwards a same-cycle write to a read of the same index.  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module register_file #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             load,
  input  logic [AW-1:0]    wr_addr,
  input  logic             enable_output,
  input  logic [AW-1:0]    rd_addr,
  input  logic             clear,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             rd_err,
  output logic [WIDTH-1:0] regA,
  output logic [DEPTH-1:0] valid
);

  // Storage covers every encodable address; slots at or above DEPTH stay zero/invalid.
  localparam int            c_slots = 1 << AW;
  localparam logic [AW:0]   c_depth = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_regs [c_slots];
  logic [c_slots-1:0] r_valid;

  logic               w_rd_in_range;
  logic               w_wr_in_range;
  logic [WIDTH-1:0]   w_rd_data;
  logic               w_rd_err;

  assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);
  assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);

`ifdef REGFILE_BYPASS_EN
  logic w_hit;
  assign w_hit = load && !clear && w_wr_in_range && (wr_addr == rd_addr);
`endif

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b1;
    if (w_rd_in_range && r_valid[rd_addr]) begin
      w_rd_data = r_regs[rd_addr];
      w_rd_err  = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    if (w_hit) begin
      w_rd_data = bus_in;
      w_rd_err  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < c_slots; i++) begin
        r_regs[i] <= '0;
      end
      r_valid <= '0;
      bus_out <= '0;
      bus_oe  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      // Read path samples pre-edge state, so it is unaffected by clear/load below.
      bus_oe  <= enable_output;
      bus_out <= enable_output ? w_rd_data : '0;
      rd_err  <= enable_output & w_rd_err;
      if (clear) begin
        for (int i = 0; i < c_slots; i++) begin
          r_regs[i] <= '0;
        end
        r_valid <= '0;
      end else if (load && w_wr_in_range) begin
        r_regs[wr_addr]  <= bus_in;
        r_valid[wr_addr] <= 1'b1;
      end
    end
  end

  assign regA  = r_regs[0];
  assign valid = r_valid[DEPTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_register_file : scoreboard bench for register_file, DEPTH=4 and DEPTH=3  |
// | instances sharing one stimulus stream. Honours REGFILE_BYPASS_EN.           |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_register_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit c_bypass = 1'b1;
`else
  localparam bit c_bypass = 1'b0;
`endif

  typedef struct {
    logic       oe;
    logic [7:0] out;
    logic       err;
    logic [7:0] rega;
    logic [3:0] valid;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus_in = '0;
  logic       load = 1'b0;
  logic [1:0] wr_addr = '0;
  logic       enable_output = 1'b0;
  logic [1:0] rd_addr = '0;
  logic       clear = 1'b0;

  logic [7:0] bus_out0, rega0, bus_out1, rega1;
  logic       bus_oe0, rd_err0, bus_oe1, rd_err1;
  logic [3:0] valid0;
  logic [2:0] valid1;

  int n_checks = 0;
  int n_fail   = 0;
  bit warm     = 1'b0;

  logic [7:0] m_regs  [2][4];
  logic [3:0] m_valid [2];
  int         m_depth [2] = '{4, 3};
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       mon_e;

  register_file #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .load(load), .wr_addr(wr_addr),
    .enable_output(enable_output), .rd_addr(rd_addr), .clear(clear),
    .bus_out(bus_out0), .bus_oe(bus_oe0), .rd_err(rd_err0), .regA(rega0), .valid(valid0)
  );

  register_file #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .load(load), .wr_addr(wr_addr),
    .enable_output(enable_output), .rd_addr(rd_addr), .clear(clear),
    .bus_out(bus_out1), .bus_oe(bus_oe1), .rd_err(rd_err1), .regA(rega1), .valid(valid1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference behaviour: what a read of the pre-edge file returns, then the edge's write effect.
  task automatic model_step(input int k, input bit rn, input bit clr, input bit ld,
                            input logic [1:0] wa, input logic [7:0] din,
                            input bit en, input logic [1:0] ra, output exp_t e);
    int  d;
    bit  in_range;
    d     = m_depth[k];
    e.oe  = 1'b0;
    e.out = 8'h00;
    e.err = 1'b0;
    if (!rn) begin
      for (int i = 0; i < 4; i++) m_regs[k][i] = 8'h00;
      m_valid[k] = 4'h0;
    end else begin
      if (en) begin
        in_range = (int'(ra) < d);
        e.oe = 1'b1;
        if (c_bypass && ld && !clr && in_range && (wa == ra)) begin
          e.out = din;
        end else if (in_range && m_valid[k][ra]) begin
          e.out = m_regs[k][ra];
        end else begin
          e.err = 1'b1;
        end
      end
      if (clr) begin
        for (int i = 0; i < 4; i++) m_regs[k][i] = 8'h00;
        m_valid[k] = 4'h0;
      end else if (ld && int'(wa) < d) begin
        m_regs[k][wa]  = din;
        m_valid[k][wa] = 1'b1;
      end
    end
    e.rega  = m_regs[k][0];
    e.valid = m_valid[k];
  endtask

  task automatic drive(input bit rn, input bit clr, input bit ld, input logic [1:0] wa,
                       input logic [7:0] din, input bit en, input logic [1:0] ra);
    exp_t e;
    @(negedge clk);
    rst_n = rn; clear = clr; load = ld; wr_addr = wa; bus_in = din;
    enable_output = en; rd_addr = ra;
    if (!rn && warm) begin
      // Reset must not act between edges.
      #1;
      check("rst_no_async_regA", rega0, m_regs[0][0]);
      check("rst_no_async_valid", valid0, m_valid[0]);
    end
    model_step(0, rn, clr, ld, wa, din, en, ra, e);
    q0.push_back(e);
    model_step(1, rn, clr, ld, wa, din, en, ra, e);
    q1.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) begin
      mon_e = q0.pop_front();
      check("d4_bus_oe", bus_oe0, mon_e.oe);
      check("d4_bus_out", bus_out0, mon_e.out);
      check("d4_rd_err", rd_err0, mon_e.err);
      check("d4_regA", rega0, mon_e.rega);
      check("d4_valid", valid0, mon_e.valid);
    end
    if (q1.size() > 0) begin
      mon_e = q1.pop_front();
      check("d3_bus_oe", bus_oe1, mon_e.oe);
      check("d3_bus_out", bus_out1, mon_e.out);
      check("d3_rd_err", rd_err1, mon_e.err);
      check("d3_regA", rega1, mon_e.rega);
      check("d3_valid", {1'b0, valid1}, mon_e.valid);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a load and read pending: both discarded.
    drive(0, 0, 1, 2'd0, 8'h5A, 1, 2'd0);
    drive(0, 0, 0, 2'd0, 8'h00, 0, 2'd0);
    warm = 1'b1;
    // Read of an unwritten register.
    drive(1, 0, 0, 2'd0, 8'h00, 1, 2'd2);
    // Load then read register 1.
    drive(1, 0, 1, 2'd1, 8'hA5, 0, 2'd0);
    drive(1, 0, 0, 2'd0, 8'h00, 1, 2'd1);
    // Load register 0, visible on regA with no read.
    drive(1, 0, 1, 2'd0, 8'h3C, 0, 2'd0);
    // Same-cycle write/read of register 3 (out of range for DEPTH=3).
    drive(1, 0, 1, 2'd3, 8'h11, 0, 2'd0);
    drive(1, 0, 1, 2'd3, 8'h77, 1, 2'd3);
    drive(1, 0, 0, 2'd0, 8'h00, 1, 2'd3);
    // Same-cycle write/read of a never-written register.
    drive(1, 0, 1, 2'd2, 8'h42, 1, 2'd2);
    // Back-to-back reads, then a read coinciding with clear+load.
    drive(1, 0, 0, 2'd0, 8'h00, 1, 2'd0);
    drive(1, 0, 0, 2'd0, 8'h00, 1, 2'd1);
    drive(1, 1, 1, 2'd2, 8'hFF, 1, 2'd1);
    drive(1, 0, 0, 2'd0, 8'h00, 1, 2'd2);
    // Reset asserted mid-operation with populated registers.
    drive(1, 0, 1, 2'd1, 8'h9E, 0, 2'd0);
    drive(0, 0, 1, 2'd0, 8'hEE, 1, 2'd1);
    drive(1, 0, 0, 2'd0, 8'h00, 1, 2'd1);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(31) != 0), ($urandom_range(15) == 0), $urandom_range(1),
            2'($urandom_range(3)), 8'($urandom), ($urandom_range(3) != 0),
            2'($urandom_range(3)));
    end

    drive(1, 0, 0, 2'd0, 8'h00, 0, 2'd0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
